// File: rtl/alu_pkg.sv
// alu_pkg: shared width, op encodings and command/result records for the ALU execute stage
package alu_pkg;
    localparam int ALU_W = 32;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;
    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [2:0]       op;
        logic             ci;
        logic             chain;
    } alu_cmd_t;
    typedef struct packed {
        logic [ALU_W-1:0] f;
        logic             co;
        logic             zero;
        logic             neg;
    } alu_res_t;
endpackage

// File: rtl/alu_32_bit.sv
// alu_32_bit: combinational 32-bit ALU; SUB computes a + ~b + Ci, logic ops force Co=0
module alu_32_bit
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             S0,
    input  logic             S1,
    input  logic             S2,
    input  logic             Ci,
    output logic [ALU_W-1:0] F,
    output logic             Co
);
    logic [2:0]     sel;
    logic           arith;
    logic [ALU_W:0] sum;
    always_comb begin
        sel   = {S2, S1, S0};
        arith = (sel == OP_ADD) || (sel == OP_SUB);
        sum   = {1'b0, a} + {1'b0, ((sel == OP_SUB) ? ~b : b)} + {{ALU_W{1'b0}}, Ci};
        F     = arith            ? sum[ALU_W-1:0]
              : sel == OP_AND  ? a & b
              : sel == OP_OR   ? a | b
              : sel == OP_XOR  ? a ^ b
              : sel == OP_NOR  ? ~(a | b)
              : sel == OP_NAND ? ~(a & b)
              :                  ~(a ^ b);
        Co    = arith && sum[ALU_W];
    end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: two-stage valid/ready pipeline around alu_32_bit; ALU_CARRY_CHAIN_EN adds Co->Ci chaining
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ALU_W-1:0] cmd_a,
    input  logic [ALU_W-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_ci,
    input  logic             cmd_chain,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ALU_W-1:0] res_f,
    output logic             res_co,
    output logic             res_zero,
    output logic             res_neg,
    output logic [TAG_W-1:0] res_tag
);
    logic             s1_valid_q, s1_valid_d;
    alu_cmd_t         s1_cmd_q, s1_cmd_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             res_valid_q, res_valid_d;
    alu_res_t         res_q, res_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             adv1, adv2, push, alu_ci, alu_co;
    logic [ALU_W-1:0] alu_f;

`ifdef ALU_CARRY_CHAIN_EN
    logic carry_q, carry_d;
    assign alu_ci  = s1_cmd_q.chain ? carry_q : s1_cmd_q.ci;
    assign carry_d = adv1 ? alu_co : carry_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) carry_q <= 1'b0;
        else        carry_q <= carry_d;
    end
`else
    // chain bit is still captured but has no effect without carry chaining
    logic chain_unused;
    assign chain_unused = s1_cmd_q.chain;
    assign alu_ci       = s1_cmd_q.ci;
`endif

    alu_32_bit u_alu (
        .a  (s1_cmd_q.a),
        .b  (s1_cmd_q.b),
        .S0 (s1_cmd_q.op[0]),
        .S1 (s1_cmd_q.op[1]),
        .S2 (s1_cmd_q.op[2]),
        .Ci (alu_ci),
        .F  (alu_f),
        .Co (alu_co)
    );

    always_comb begin
        adv2        = !res_valid_q || res_ready;
        adv1        = s1_valid_q && adv2;
        cmd_ready   = !s1_valid_q || adv2;
        push        = cmd_valid && cmd_ready;
        s1_valid_d  = push || (s1_valid_q && !adv1);
        s1_cmd_d    = push ? alu_cmd_t'({cmd_a, cmd_b, cmd_op, cmd_ci, cmd_chain}) : s1_cmd_q;
        s1_tag_d    = push ? tag_q : s1_tag_q;
        tag_d       = push ? tag_q + 1'b1 : tag_q;
        res_valid_d = adv2 ? s1_valid_q : res_valid_q;
        res_d       = adv1 ? alu_res_t'({alu_f, alu_co, alu_f == '0, alu_f[ALU_W-1]}) : res_q;
        res_tag_d   = adv1 ? s1_tag_q : res_tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_cmd_q    <= '0;
            s1_tag_q    <= '0;
            tag_q       <= '0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
            res_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_cmd_q    <= s1_cmd_d;
            s1_tag_q    <= s1_tag_d;
            tag_q       <= tag_d;
            res_valid_q <= res_valid_d;
            res_q       <= res_d;
            res_tag_q   <= res_tag_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_f     = res_q.f;
    assign res_co    = res_q.co;
    assign res_zero  = res_q.zero;
    assign res_neg   = res_q.neg;
    assign res_tag   = res_tag_q;
endmodule
